// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending/latency tracking for RAW/WAW stall and bypass select; HAZARD_SCOREBOARD_STATS_EN adds stall/forward counters
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int LAT_W = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en_fwd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          issue_valid,
  input  logic                          issue_wb_en,
  input  logic [REG_ADDR_W-1:0]         issue_dest,
  input  logic [LAT_W-1:0]              issue_lat,
  input  logic                          flush,
  input  logic                          wb_valid,
  input  logic [REG_ADDR_W-1:0]         wb_dest,
  output logic                          hazard_detected,
  output logic [NUM_SRC-1:0]            fwd_sel,
`ifdef HAZARD_SCOREBOARD_STATS_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   fwd_events,
  output logic [15:0]                   waw_stalls,
`endif
  output logic                          issue_accept
);
  localparam int NREG = 2 ** REG_ADDR_W;
  logic [NREG-1:0]  pend;
  logic [LAT_W-1:0] rem [NREG];
  logic [NUM_SRC-1:0] live, raw, fwd_c;
  logic waw;
  logic [LAT_W-1:0] lat_m1;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] a;
    assign a = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
    assign live[i] = src_used[i] & pend[a] & ~(wb_valid & (wb_dest == a));
    assign raw[i] = live[i] & (~en_fwd | (rem[a] != '0));
    assign fwd_c[i] = en_fwd & live[i] & (rem[a] == '0);
  end
  always_comb begin
    waw = issue_valid & issue_wb_en & pend[issue_dest] & ~(wb_valid & (wb_dest == issue_dest));
    hazard_detected = issue_valid & ~flush & ((|raw) | waw);
    fwd_sel = hazard_detected ? '0 : fwd_c;
    issue_accept = issue_valid & ~flush & ~hazard_detected;
    lat_m1 = (issue_lat == '0) ? '0 : issue_lat - LAT_W'(1);
  end
  // r0 is skipped so it can never become pending
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
      for (int r = 0; r < NREG; r++) rem[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_accept & issue_wb_en & (issue_dest == REG_ADDR_W'(r))) begin
          pend[r] <= 1'b1;
          rem[r] <= lat_m1;
        end else if (wb_valid & (wb_dest == REG_ADDR_W'(r))) begin
          pend[r] <= 1'b0;
          rem[r] <= '0;
        end else if (pend[r] & (rem[r] != '0)) begin
          rem[r] <= rem[r] - LAT_W'(1);
        end
      end
    end
  end
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [32:0] fsum;
  always_comb begin
    fsum = {1'b0, fwd_events};
    for (int i = 0; i < NUM_SRC; i++) fsum = fsum + 33'(fwd_sel[i]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      fwd_events <= '0;
      waw_stalls <= '0;
    end else begin
      if (hazard_detected & (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      fwd_events <= fsum[32] ? '1 : fsum[31:0];
      if (hazard_detected & ~(|raw) & (waw_stalls != '1)) waw_stalls <= waw_stalls + 16'd1;
    end
  end
`endif
endmodule
